// File: rtl/pcileech_sysrst_ctl_if.sv
// pcileech_sysrst_ctl_if
//   Board-facing bundle of the system reset controller. It carries the raw
//   push-buttons into the controller and the reset, tick and LED signals out
//   to the downstream blocks.
//   master : the controller. It samples the buttons and drives the outputs.
//   slave  : a consumer or the board side. It drives the buttons and samples
//            the outputs.
interface pcileech_sysrst_ctl_if;
  logic        gpio_sw_north;   // raw reset button, async, active-high
  logic        gpio_sw_south;   // raw invert button, async, active-high
  logic        rst;             // sync active-high reset
  logic        ft601_rst_n;     // FT601 reset pad
  logic [63:0] tickcount64;     // free-running cycle counter
  logic        led_heartbeat;   // heartbeat LED
  logic        sw_south_db;     // debounced south button
  logic [7:0]  rst_events;      // saturating count of button resets

  modport master (
    input  gpio_sw_north, gpio_sw_south,
    output rst, ft601_rst_n, tickcount64, led_heartbeat, sw_south_db, rst_events
  );

  modport slave (
    output gpio_sw_north, gpio_sw_south,
    input  rst, ft601_rst_n, tickcount64, led_heartbeat, sw_south_db, rst_events
  );
endinterface

// File: rtl/pcileech_sysrst_ctl.sv
// pcileech_sysrst_ctl
//   System reset and housekeeping controller. It provides the following:
//   - power-on reset hold
//   - 2-flop synchronisation and debounce of the board buttons
//   - a minimum reset stretch after a button release
//   - a 64-bit tick counter and a heartbeat LED
//   Ports:
//     clk   : system clock
//     rst_n : async active-low reset (clock-wizard locked)
//     sys   : pcileech_sysrst_ctl_if.master. It carries the buttons in and
//             the outputs rst, ft601_rst_n, tickcount64, led_heartbeat,
//             sw_south_db and rst_events.

// Per-button synchroniser and debouncer.
//   raw : asynchronous button input
//   db  : debounced level. It changes only after the synchronised input has
//         differed from it for DEBOUNCE_CYCLES consecutive cycles.
module pcileech_sysrst_db #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);
  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic        sync1, sync2;
  logic [19:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        // The input has disagreed long enough, so accept the new level.
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end
endmodule

module pcileech_sysrst_ctl #(
  parameter int POR_CYCLES      = 64,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int MIN_RST_CYCLES  = 64,
  parameter int LED_TICK_BIT    = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pcileech_sysrst_ctl_if.master sys
);
  localparam int          NUM_BTN  = 2;   // [0] north (reset), [1] south (invert)
  localparam logic [15:0] POR_LAST = 16'(POR_CYCLES - 1);
  localparam logic [15:0] STR_LAST = 16'(MIN_RST_CYCLES - 1);

  typedef enum logic [1:0] {
    POR_HOLD = 2'd0,
    BTN_RST  = 2'd1,
    STRETCH  = 2'd2,
    RUN      = 2'd3
  } state_t;

  logic [NUM_BTN-1:0] btn_raw, btn_db;
  logic               north_db, south_db;

  assign btn_raw  = {sys.gpio_sw_south, sys.gpio_sw_north};
  assign north_db = btn_db[0];
  assign south_db = btn_db[1];

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      pcileech_sysrst_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_raw[g]),
        .db    (btn_db[g])
      );
    end
  endgenerate

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ev_inc;
  logic        rst_q;
  logic [63:0] tick_q;
  logic        led_q;
  logic [7:0]  ev_q;

  // The sequencing counter is shared by POR_HOLD and STRETCH. It is cleared
  // whenever a state hands over to another state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_inc  = 1'b0;
    unique case (state_q)
      POR_HOLD: begin
        if (cnt_q == POR_LAST) begin
          state_d = north_db ? BTN_RST : RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        if (north_db) begin
          state_d = BTN_RST;
          cnt_d   = '0;
          ev_inc  = 1'b1;
        end
      end
      BTN_RST: begin
        cnt_d = '0;
        if (!north_db) state_d = STRETCH;
      end
      STRETCH: begin
        if (north_db) begin
          // A re-press extends the same reset. It is not counted as a new event.
          state_d = BTN_RST;
          cnt_d   = '0;
        end else if (cnt_q == STR_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = POR_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= POR_HOLD;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
      tick_q  <= '0;
      led_q   <= 1'b0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // rst is loaded from the next state, so it moves on the same edge as
      // the transition into or out of RUN.
      rst_q   <= (state_d != RUN);
      tick_q  <= tick_q + 64'd1;
      led_q   <= north_db ^ south_db ^ tick_q[LED_TICK_BIT];
      if (ev_inc && ev_q != 8'hFF) ev_q <= ev_q + 8'd1;
    end
  end

  assign sys.rst           = rst_q;
  assign sys.ft601_rst_n   = ~rst_q;
  assign sys.tickcount64   = tick_q;
  assign sys.led_heartbeat = led_q;
  assign sys.sw_south_db   = south_db;
  assign sys.rst_events    = ev_q;
endmodule

// File: tb/tb_pcileech_sysrst_ctl.sv
// Directed bench for pcileech_sysrst_ctl.
// dut1 uses the nominal bench parameters (POR 64, debounce 16, stretch 8,
// LED bit 4). With a 16-cycle debounce a button cannot be released and
// re-pressed within an 8-cycle stretch. dut2 therefore uses a 1-cycle
// debounce to exercise the re-press-in-STRETCH path.
module tb_pcileech_sysrst_ctl;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcileech_sysrst_ctl_if s1 ();
  pcileech_sysrst_ctl_if s2 ();

  pcileech_sysrst_ctl #(.POR_CYCLES(64), .DEBOUNCE_CYCLES(16), .MIN_RST_CYCLES(8),
                        .LED_TICK_BIT(LB)) dut1 (.clk(clk), .rst_n(rst_n), .sys(s1));
  pcileech_sysrst_ctl #(.POR_CYCLES(64), .DEBOUNCE_CYCLES(1), .MIN_RST_CYCLES(8),
                        .LED_TICK_BIT(LB)) dut2 (.clk(clk), .rst_n(rst_n), .sys(s2));

  int checks = 0;
  int errors = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    s1.gpio_sw_north = 1'b0; s1.gpio_sw_south = 1'b0;
    s2.gpio_sw_north = 1'b0; s2.gpio_sw_south = 1'b0;
    rst_n = 1'b0;
    step(3);
    // Buttons pressed while in reset must not be seen.
    s1.gpio_sw_north = 1'b1; s1.gpio_sw_south = 1'b1;
    step(4);
    checks++; if (s1.rst !== 1'b1) begin errors++; $display("FAIL reset_rst: got %b expected 1", s1.rst); end
    checks++; if (s1.ft601_rst_n !== 1'b0) begin errors++; $display("FAIL reset_ft601: got %b expected 0", s1.ft601_rst_n); end
    checks++; if (s1.tickcount64 !== 64'd0) begin errors++; $display("FAIL reset_tick: got %0d expected 0", s1.tickcount64); end
    checks++; if (s1.led_heartbeat !== 1'b0) begin errors++; $display("FAIL reset_led: got %b expected 0", s1.led_heartbeat); end
    checks++; if (s1.sw_south_db !== 1'b0) begin errors++; $display("FAIL reset_south_db: got %b expected 0", s1.sw_south_db); end
    checks++; if (s1.rst_events !== 8'd0) begin errors++; $display("FAIL reset_events: got %0d expected 0", s1.rst_events); end
    s1.gpio_sw_north = 1'b0; s1.gpio_sw_south = 1'b0;
  endtask

  task automatic test_por(input string tag);
    int n;
    bit ft_ok;
    n = 0;
    ft_ok = 1'b1;
    rst_n = 1'b1;
    while (n < 200) begin
      step(1);
      n++;
      if (s1.ft601_rst_n !== ~s1.rst) ft_ok = 1'b0;
      if (s1.rst === 1'b0) break;
    end
    checks++; if (n != 64) begin errors++; $display("FAIL %s_len: got %0d edges expected 64", tag, n); end
    checks++; if (s1.tickcount64 !== 64'd64) begin errors++; $display("FAIL %s_tick: got %0d expected 64", tag, s1.tickcount64); end
    checks++; if (!ft_ok || s1.ft601_rst_n !== 1'b1) begin errors++; $display("FAIL %s_ft601: got %b expected 1 and ~rst", tag, s1.ft601_rst_n); end
    checks++; if (s2.rst !== 1'b0) begin errors++; $display("FAIL %s_dut2_rst: got %b expected 0", tag, s2.rst); end
    checks++; if (s1.rst_events !== 8'd0) begin errors++; $display("FAIL %s_events: got %0d expected 0", tag, s1.rst_events); end
  endtask

  task automatic test_glitch;
    bit ok;
    ok = 1'b1;
    s1.gpio_sw_north = 1'b1;
    step(10);
    s1.gpio_sw_north = 1'b0;
    repeat (40) begin
      step(1);
      if (s1.rst !== 1'b0) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL glitch_rst: got a rst pulse expected none"); end
    checks++; if (s1.rst_events !== 8'd0) begin errors++; $display("FAIL glitch_events: got %0d expected 0", s1.rst_events); end
  endtask

  task automatic test_button;
    int n;
    s1.gpio_sw_north = 1'b1;
    n = 0;
    while (s1.rst === 1'b0 && n < 100) begin step(1); n++; end
    checks++; if (n != 19) begin errors++; $display("FAIL button_rise: got %0d edges expected 19", n); end
    step(40 - n);
    s1.gpio_sw_north = 1'b0;
    n = 0;
    while (s1.rst === 1'b1 && n < 200) begin step(1); n++; end
    checks++; if (n != 27) begin errors++; $display("FAIL button_fall: got %0d edges expected 27", n); end
    checks++; if (s1.rst_events !== 8'd1) begin errors++; $display("FAIL button_events: got %0d expected 1", s1.rst_events); end
  endtask

  task automatic test_restretch;
    int n;
    bit ok;
    s2.gpio_sw_north = 1'b1;
    n = 0;
    while (s2.rst === 1'b0 && n < 100) begin step(1); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL restretch_rise: got %0d edges expected 4", n); end
    step(6);
    // Release, then press again so that the debounced press lands 2-3 cycles
    // into STRETCH.
    s2.gpio_sw_north = 1'b0;
    ok = 1'b1;
    repeat (3) begin step(1); if (s2.rst !== 1'b1) ok = 1'b0; end
    s2.gpio_sw_north = 1'b1;
    repeat (20) begin step(1); if (s2.rst !== 1'b1) ok = 1'b0; end
    checks++; if (!ok) begin errors++; $display("FAIL restretch_hold: got rst drop expected rst held"); end
    s2.gpio_sw_north = 1'b0;
    n = 0;
    while (s2.rst === 1'b1 && n < 100) begin step(1); n++; end
    checks++; if (n != 12) begin errors++; $display("FAIL restretch_fall: got %0d edges expected 12", n); end
    checks++; if (s2.rst_events !== 8'd1) begin errors++; $display("FAIL restretch_events: got %0d expected 1", s2.rst_events); end
  endtask

  task automatic test_heartbeat;
    int toggles, bad;
    logic prev;
    logic [63:0] t;
    toggles = 0;
    bad = 0;
    prev = s1.led_heartbeat;
    repeat (64) begin
      step(1);
      t = s1.tickcount64 - 64'd1;
      if (s1.led_heartbeat !== t[LB]) bad++;
      if (s1.led_heartbeat !== prev) toggles++;
      prev = s1.led_heartbeat;
    end
    checks++; if (toggles != 4) begin errors++; $display("FAIL hb_toggles: got %0d expected 4", toggles); end
    checks++; if (bad != 0) begin errors++; $display("FAIL hb_phase: got %0d bad cycles expected 0", bad); end
    s1.gpio_sw_south = 1'b1;
    step(25);
    checks++; if (s1.sw_south_db !== 1'b1) begin errors++; $display("FAIL south_db_set: got %b expected 1", s1.sw_south_db); end
    bad = 0;
    repeat (32) begin
      step(1);
      t = s1.tickcount64 - 64'd1;
      if (s1.led_heartbeat !== ~t[LB]) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hb_invert: got %0d bad cycles expected 0", bad); end
    checks++; if (s1.rst !== 1'b0) begin errors++; $display("FAIL south_no_rst: got %b expected 0", s1.rst); end
    s1.gpio_sw_south = 1'b0;
    step(25);
    checks++; if (s1.sw_south_db !== 1'b0) begin errors++; $display("FAIL south_db_clr: got %b expected 0", s1.sw_south_db); end
  endtask

  task automatic test_abort;
    s1.gpio_sw_north = 1'b1;
    step(25);
    s1.gpio_sw_north = 1'b0;
    step(22);   // the state entered STRETCH 3 edges ago
    checks++; if (s1.rst !== 1'b1 || s1.rst_events !== 8'd2) begin
      errors++; $display("FAIL abort_pre: got rst=%b events=%0d expected rst=1 events=2", s1.rst, s1.rst_events);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (s1.rst !== 1'b1 || s1.ft601_rst_n !== 1'b0) begin
      errors++; $display("FAIL abort_rst: got rst=%b ft=%b expected rst=1 ft=0", s1.rst, s1.ft601_rst_n);
    end
    checks++; if (s1.tickcount64 !== 64'd0 || s1.rst_events !== 8'd0 || s1.led_heartbeat !== 1'b0
                  || s1.sw_south_db !== 1'b0) begin
      errors++; $display("FAIL abort_vals: got tick=%0d events=%0d led=%b south=%b expected all 0",
                         s1.tickcount64, s1.rst_events, s1.led_heartbeat, s1.sw_south_db);
    end
    step(3);
    test_por("abort_por");
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      s1.gpio_sw_north = 1'b1;
      step(22);
      s1.gpio_sw_north = 1'b0;
      step(30);
      if (i == 9) begin
        checks++; if (s1.rst_events !== 8'd10) begin errors++; $display("FAIL sat_10: got %0d expected 10", s1.rst_events); end
      end
    end
    checks++; if (s1.rst_events !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", s1.rst_events); end
    checks++; if (s1.rst !== 1'b0) begin errors++; $display("FAIL sat_rst: got %b expected 0", s1.rst); end
  endtask

  initial begin
    test_reset();
    test_por("por");
    test_glitch();
    test_button();
    test_restretch();
    test_heartbeat();
    test_abort();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
